dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with port-1 burst lock
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              gnt0_o,
  output logic              rvalid0_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic              stall_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic              lock1_i,
  output logic              gnt1_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            prio_q, prio_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            gnt0, gnt1;
  logic            arb0, arb1;
  logic            rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  // Round-robin winner used whenever the port-1 lock is not in force
  always_comb begin
    arb0 = req0_i & (~req1_i | ~prio_q);
    arb1 = req1_i & (~req0_i | prio_q);
  end

  // Next-state, priority, burst count and grant decode
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    bcnt_d  = bcnt_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      ARB: begin
        gnt0 = arb0;
        gnt1 = arb1;
        if (arb0 | arb1) prio_d = arb0;
        if (arb1 & lock1_i) begin
          state_d = LOCK1;
          bcnt_d  = BW'(1);
        end
      end
      LOCK1: begin
        if (!req1_i || !lock1_i) begin
          // Lock released: behave like ARB for this cycle and leave the burst
          gnt0 = arb0;
          gnt1 = arb1;
          if (arb0 | arb1) prio_d = arb0;
          state_d = ARB;
          bcnt_d  = '0;
        end else if (bcnt_q < BMAX) begin
          gnt1   = 1'b1;
          bcnt_d = bcnt_q + BW'(1);
        end else if (req0_i) begin
          // Burst budget spent and the CPU is waiting: force one CPU slot
          gnt0    = 1'b1;
          state_d = ARB;
          bcnt_d  = '0;
          prio_d  = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end
      default: begin
        state_d = ARB;
        bcnt_d  = '0;
      end
    endcase
    if (!start_i) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // Arbitration state register
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q <= ARB;
      prio_q  <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Capture read data for a granted read; rvalid is a one-cycle pulse
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gnt0 & ~we0_i;
      rvalid1_q <= gnt1 & ~we1_i;
      if (gnt0 & ~we0_i) rdata0_q <= mem_rdata_i;
      if (gnt1 & ~we1_i) rdata1_q <= mem_rdata_i;
    end
  end

  // Shared memory port mux; idle cycles drive zeros
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    if (gnt0) begin
      mem_addr_o  = addr0_i;
      mem_we_o    = we0_i;
      mem_wdata_o = wdata0_i;
    end else if (gnt1) begin
      mem_addr_o  = addr1_i;
      mem_we_o    = we1_i;
      mem_wdata_o = wdata1_i;
    end
  end

  assign gnt0_o    = gnt0;
  assign gnt1_o    = gnt1;
  assign stall_o   = req0_i & ~gnt0;
  assign rvalid0_o = rvalid0_q;
  assign rvalid1_o = rvalid1_q;
  assign rdata0_o  = rdata0_q;
  assign rdata1_o  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          start_i = 1'b0;
  logic          req0_i = 1'b0, we0_i = 1'b0, req1_i = 1'b0, we1_i = 1'b0, lock1_i = 1'b0;
  logic [AW-1:0] addr0_i = '0, addr1_i = '0;
  logic [DW-1:0] wdata0_i = '0, wdata1_i = '0, mem_rdata_i = '0;
  logic          gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, stall_o, mem_we_o;
  logic [DW-1:0] rdata0_o, rdata1_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit          m_locked;
  int          m_burst;
  int          m_prio;
  bit          e_rv0, e_rv1;
  logic [DW-1:0] e_rd0, e_rd1;
  int          last_win;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk_i(clk), .start_i(start_i),
    .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
    .gnt0_o(gnt0_o), .rvalid0_o(rvalid0_o), .rdata0_o(rdata0_o), .stall_o(stall_o),
    .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
    .lock1_i(lock1_i),
    .gnt1_o(gnt1_o), .rvalid1_o(rvalid1_o), .rdata1_o(rdata1_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_burst = 0; m_prio = 0;
    e_rv0 = 0; e_rv1 = 0; e_rd0 = '0; e_rd1 = '0;
    last_win = -1;
  endtask

  // one clock of stimulus: drive at negedge, check, then advance the model
  task automatic cycle(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input bit l1, input logic [DW-1:0] md);
    int win;
    @(negedge clk);
    req0_i = r0; we0_i = w0; addr0_i = a0; wdata0_i = d0;
    req1_i = r1; we1_i = w1; addr1_i = a1; wdata1_i = d1;
    lock1_i = l1; mem_rdata_i = md;
    #1;
    win = -1;
    if (m_locked && r1 && l1) begin
      if (m_burst < MB) begin
        win = 1; m_burst = m_burst + 1;
      end else if (r0) begin
        win = 0; m_locked = 0; m_burst = 0; m_prio = 1;
      end else begin
        win = 1;
      end
    end else begin
      if (r0 && r1) win = m_prio;
      else if (r0) win = 0;
      else if (r1) win = 1;
      m_locked = 0; m_burst = 0;
      if (win >= 0) m_prio = 1 - win;
      if (win == 1 && l1) begin
        m_locked = 1; m_burst = 1;
      end
    end
    check("gnt0", 64'(gnt0_o), 64'(win == 0));
    check("gnt1", 64'(gnt1_o), 64'(win == 1));
    check("stall", 64'(stall_o), 64'(r0 && win != 0));
    check("mem_we", 64'(mem_we_o), 64'(win == 0 ? w0 : (win == 1 ? w1 : 1'b0)));
    check("mem_addr", 64'(mem_addr_o), 64'(win == 0 ? a0 : (win == 1 ? a1 : '0)));
    check("mem_wdata", 64'(mem_wdata_o), 64'(win == 0 ? d0 : (win == 1 ? d1 : '0)));
    check("rvalid0", 64'(rvalid0_o), 64'(e_rv0));
    check("rvalid1", 64'(rvalid1_o), 64'(e_rv1));
    check("rdata0", 64'(rdata0_o), 64'(e_rd0));
    check("rdata1", 64'(rdata1_o), 64'(e_rd1));
    e_rv0 = (win == 0) && !w0;
    e_rv1 = (win == 1) && !w1;
    if (e_rv0) e_rd0 = md;
    if (e_rv1) e_rd1 = md;
    last_win = win;
  endtask

  // asynchronous reset pulse spanning one rising edge; called right after a cycle
  task automatic pulse_reset();
    #1 start_i = 1'b0;
    #1;
    check("rst_gnt0", 64'(gnt0_o), 64'(0));
    check("rst_gnt1", 64'(gnt1_o), 64'(0));
    check("rst_mem_we", 64'(mem_we_o), 64'(0));
    check("rst_rvalid0", 64'(rvalid0_o), 64'(0));
    check("rst_rvalid1", 64'(rvalid1_o), 64'(0));
    @(posedge clk); #1;
    check("rst_hold_rvalid1", 64'(rvalid1_o), 64'(0));
    check("rst_rdata1", 64'(rdata1_o), 64'(0));
    model_reset();
    req0_i = 0; req1_i = 0; lock1_i = 0;
    @(negedge clk);
    start_i = 1'b1;
  endtask

  bit          p0, p1, pw0, pw1, pl1;
  logic [AW-1:0] pa0, pa1;
  logic [DW-1:0] pd0, pd1;

  initial begin
    model_reset();
    // reset state with both ports requesting
    req0_i = 1; req1_i = 1; lock1_i = 1; we0_i = 1; we1_i = 1;
    #12;
    check("init_gnt0", 64'(gnt0_o), 64'(0));
    check("init_gnt1", 64'(gnt1_o), 64'(0));
    check("init_mem_we", 64'(mem_we_o), 64'(0));
    check("init_rvalid0", 64'(rvalid0_o), 64'(0));
    check("init_rdata0", 64'(rdata0_o), 64'(0));
    req0_i = 0; req1_i = 0; lock1_i = 0;
    @(negedge clk);
    start_i = 1'b1;

    // alternating contested reads, first contested cycle goes to port 0
    for (int i = 0; i < 4; i++)
      cycle(1, 0, 32'h100 + i, '0, 1, 0, 32'h200 + i, '0, 0, 32'hA000_0000 + i);
    check("alt_last_winner", 64'(last_win), 64'(1));
    // single CPU write
    cycle(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, '0, '0, 0, 32'h1234);
    // 8 cycles of locked port-1 reads against a waiting CPU
    for (int i = 0; i < 8; i++)
      cycle(1, 0, 32'h30, '0, 1, 0, 32'h40 + i, '0, 1, $urandom);
    // uncontested locked burst, then drop the lock with the CPU waiting
    for (int i = 0; i < 6; i++)
      cycle(0, 0, '0, '0, 1, 0, 32'h50 + i, '0, 1, $urandom);
    cycle(1, 0, 32'h60, '0, 1, 0, 32'h61, '0, 0, $urandom);
    // idle
    cycle(0, 0, '0, '0, 0, 0, '0, '0, 0, $urandom);
    cycle(0, 1, 32'h7, 32'h8, 0, 1, 32'h9, 32'hA, 1, $urandom);
    // reset mid-burst with a port-1 read in flight
    cycle(0, 0, '0, '0, 1, 0, 32'h70, '0, 1, $urandom);
    cycle(1, 0, 32'h71, '0, 1, 0, 32'h72, '0, 1, 32'hCAFE_F00D);
    pulse_reset();
    cycle(1, 0, 32'h80, '0, 1, 0, 32'h81, '0, 1, $urandom);
    check("post_rst_port0", 64'(last_win), 64'(0));

    // randomized traffic; requests hold until granted
    p0 = 0; p1 = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!p0 || last_win == 0) begin
        p0 = ($urandom_range(0, 2) != 0); pw0 = $urandom_range(0, 1);
        pa0 = $urandom; pd0 = $urandom;
      end
      if (!p1 || last_win == 1) begin
        p1 = ($urandom_range(0, 2) != 0); pw1 = $urandom_range(0, 1);
        pa1 = $urandom; pd1 = $urandom;
      end
      if ($urandom_range(0, 7) == 0) pl1 = $urandom_range(0, 4) != 0;
      cycle(p0, pw0, pa0, pd0, p1, pw1, pa1, pd1, pl1, $urandom);
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
        p0 = 0; p1 = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
